// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto one single-port memory with fixed read
// latency. One access in flight; ties resolved round-robin against the last owner.
module mem_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic       OWN_IF = 1'b0;
  localparam logic       OWN_DM = 1'b1;
  localparam logic [3:0] LAST   = 4'(LATENCY - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       owner;
  logic       last_owner;
  logic       pick_dm;

  // Data port wins when alone, or on a tie when fetch was served last.
  always_comb begin
    pick_dm = dm_req && (!if_req || last_owner == OWN_IF);
  end

  // mem_wr doubles as the latched store flag for the whole ACCESS phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      owner      <= OWN_IF;
      last_owner <= OWN_DM;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      mem_en     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      mem_en <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            owner      <= pick_dm;
            last_owner <= pick_dm;
            mem_addr   <= pick_dm ? dm_addr : if_addr;
            mem_wr     <= pick_dm & dm_wr;
            mem_wdata  <= pick_dm ? dm_wdata : 32'd0;
            mem_en     <= 1'b1;
            cnt        <= '0;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST) begin
            if (!mem_wr) begin
              if (owner == OWN_DM) dm_rdata <= mem_rdata;
              else                 if_rdata <= mem_rdata;
            end
            if (owner == OWN_DM) dm_ack <= 1'b1;
            else                 if_ack <= 1'b1;
            mem_wr <= 1'b0;
            state  <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 LATENCY, 2, clock edges from grant edge to mem_rdata sample edge; legal range 1..8.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 if_req  input  1  fetch-port read request, held until if_ack.
REQ-005 if_addr  input  32  fetch address, stable while if_req high.
REQ-006 if_rdata  output  32  fetch read data, valid when if_ack high, held until next if_ack.
REQ-007 if_ack  output  1  one-cycle completion pulse for fetch port.
REQ-008 dm_req  input  1  data-port request, held until dm_ack.
REQ-009 dm_wr  input  1  1 = store, 0 = load; stable while dm_req high.
REQ-010 dm_addr  input  32  data address.
REQ-011 dm_wdata  input  32  store data.
REQ-012 dm_rdata  output  32  load data, valid when dm_ack high, held until next load dm_ack.
REQ-013 dm_ack  output  1  one-cycle completion pulse for data port.
REQ-014 mem_en  output  1  memory access strobe.
REQ-015 mem_wr  output  1  memory write enable, qualified by mem_en.
REQ-016 mem_addr  output  32  memory address.
REQ-017 mem_wdata  output  32  memory write data.
REQ-018 mem_rdata  input  32  memory read data.

Function
REQ-019 FSM states IDLE, ACCESS, RESP; one shared single-port memory serves both ports, one access in flight at a time.
REQ-020 IDLE: if any req high at a rising edge (grant edge), latch owner, addr, wr, wdata; go to ACCESS, cnt=0.
REQ-021 Fetch grants force wr=0; wdata latched as 0.
REQ-022 Tie (both req high in IDLE): round-robin; winner is port not equal to last_owner; last_owner updates on every grant.
REQ-023 Single requester wins regardless of last_owner.
REQ-024 ACCESS: mem_en=1 only in first ACCESS cycle (cnt==0); mem_addr/mem_wr/mem_wdata driven from latched regs for all ACCESS cycles; cnt increments each edge.
REQ-025 On edge where cnt==LATENCY-1 in ACCESS: if owner read, capture mem_rdata into owner's rdata reg; go to RESP.
REQ-026 LATENCY=1: ACCESS lasts exactly one cycle, mem_rdata captured on edge following grant edge.
REQ-027 RESP: owner's ack=1 for exactly that cycle; next edge -> IDLE; new request not granted until IDLE edge.
REQ-028 Latency: grant edge G -> ack high in cycle after edge G+LATENCY; throughput one access per LATENCY+2 cycles.
REQ-029 Store completion pulses dm_ack; dm_rdata unchanged.
REQ-030 Requests arriving during ACCESS/RESP wait; no request lost or reordered; non-owner ack stays 0.
REQ-031 req deasserted mid-access (protocol violation): access completes, ack still pulsed.
REQ-032 if_ack and dm_ack never high in same cycle; mem_wr never 1 for fetch owner.
REQ-033 mem_en, mem_wr 0 in IDLE and RESP; mem_addr/mem_wdata hold last latched value.

Reset
REQ-034 rst low asynchronously forces state IDLE, cnt=0, all acks/mem_en/mem_wr 0, mem_addr/mem_wdata/if_rdata/dm_rdata 0, last_owner=data (fetch wins first tie).
REQ-035 Reset mid-ACCESS abandons access, no ack issued; first grant after rst rises occurs on first rising edge with rst high.

Verification (LATENCY=2)
REQ-036 if_req, if_addr=0x100, mem returns 0x00500093 -> one mem_en cycle addr 0x100 wr=0, if_ack one cycle after grant edge+2, if_rdata=0x00500093.
REQ-037 dm_req wr=1 addr 0x40 wdata 0xDEADBEEF -> mem_en=1 mem_wr=1 addr 0x40 wdata 0xDEADBEEF, dm_ack pulse, dm_rdata unchanged.
REQ-038 if_req and dm_req both high from reset -> fetch granted first, data second, then fetch; ack order if,dm,if; each gap 4 cycles.
REQ-039 dm load addr 0x80 with if_req rising during ACCESS -> dm_ack first, if granted on IDLE edge after RESP, no overlap.
REQ-040 rst low during ACCESS cycle cnt=1 -> all outputs 0 immediately, no ack; after release pending if_req granted on first edge.
REQ-041 LATENCY=1 rebuild, back-to-back fetch 0x0,0x4 -> acks every 3 cycles, rdata matches memory model.
